// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access pipeline stage and the units that
// reuse its beat address generator.
//   - MEM_* : bit positions inside the 5-bit memory control word
//   - mem_state_t : access FSM states
//   - memwb_t : MEM/WB bundle handed to the writeback stage
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_RD   = 0;
  localparam int MEM_WR   = 1;
  localparam int MEM_VEC  = 2;
  localparam int MEM_BYTE = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] res_alu;
    logic [31:0] rdata;
    logic [3:0]  dest;
  } memwb_t;

endpackage

// File: rtl/mem_beat_addr_gen.sv
// -----------------------------------------------------------------------------
// mem_beat_addr_gen
// Purely combinational byte address for one beat of a multi-beat access.
//   base   : access base address
//   stride : vector stride in bytes (used only when vec=1)
//   beat   : beat index
//   vec    : 1 = strided vector access, 0 = consecutive bytes
//   addr   : base + beat*step, wrapping modulo 2^ADDR_W
// -----------------------------------------------------------------------------
module mem_beat_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int BEAT_W = 2
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        stride,
  input  logic [BEAT_W-1:0] beat,
  input  logic              vec,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] idx;

  assign step = vec ? ADDR_W'(stride) : ADDR_W'(1);
  assign idx  = ADDR_W'(beat);
  // Truncation to ADDR_W bits gives the required address wrap.
  assign addr = base + idx * step;

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Consumes the EX/MEM bundle and performs the data-memory access over a
// byte-wide req/ack port, then emits the MEM/WB bundle with a valid strobe.
//   clk, rst_n         : clock, asynchronous active-low reset
//   mem_in, wb_in, r1_in, r2_in, res_alu_in, dest_in, in_valid : EX/MEM bundle
//   stall_out          : upstream must hold its bundle while high
//   mem_req/we/addr/wdata, mem_ack/rdata : byte memory port
//   wb_out, res_alu_out, rdata_out, dest_out, out_valid : MEM/WB bundle
//   err_out            : pulses with out_valid for an illegal control word
//
// Handshake: a memory beat completes on a rising edge where mem_req and
// mem_ack are both high; mem_addr/mem_we/mem_wdata stay stable until then.
// An upstream bundle is taken on a rising edge in IDLE with in_valid high.
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_W = 16,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        mem_in,
  input  logic [1:0]        wb_in,
  input  logic [31:0]       r1_in,
  input  logic [31:0]       r2_in,
  input  logic [31:0]       res_alu_in,
  input  logic [3:0]        dest_in,
  input  logic              in_valid,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        wb_out,
  output logic [31:0]       res_alu_out,
  output logic [31:0]       rdata_out,
  output logic [3:0]        dest_out,
  output logic              out_valid,
  output logic              err_out
);
  import mem_pkg::*;

  localparam int BEAT_W = $clog2(BEATS);

  // 32-bit data over a byte port fixes the beat count; the stride is 8 bits.
  if (BEATS != 4 || ADDR_W <= 8) begin : g_bad_param
    $error("mem_access_stage: BEATS must be 4 and ADDR_W must exceed 8");
  end

  mem_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        cap_wb_q, cap_wb_d;
  logic [31:0]       cap_res_q, cap_res_d;
  logic [3:0]        cap_dest_q, cap_dest_d;
  logic [7:0]        cap_stride_q, cap_stride_d;
  logic [31:0]       cap_wdata_q, cap_wdata_d;
  logic              cap_wr_q, cap_wr_d;
  logic              cap_vec_q, cap_vec_d;
  logic              cap_byte_q, cap_byte_d;
  memwb_t            out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic              in_rd, in_wr, in_access;
  logic [BEAT_W-1:0] last_beat;
  logic [31:0]       rdata_merge;
  logic [ADDR_W-1:0] beat_addr;
  logic              unused_ok;

  assign in_rd     = mem_in[MEM_RD];
  assign in_wr     = mem_in[MEM_WR];
  assign in_access = in_rd ^ in_wr;
  assign unused_ok = ^{r1_in[31:8], mem_in[4]};

  // Vector wins over byte: only a non-vector byte access is a single beat.
  assign last_beat = (cap_byte_q && !cap_vec_q) ? '0 : BEAT_W'(BEATS - 1);

  mem_beat_addr_gen #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) u_addr_gen (
    .base   (cap_res_q[ADDR_W-1:0]),
    .stride (cap_stride_q),
    .beat   (beat_q),
    .vec    (cap_vec_q),
    .addr   (beat_addr)
  );

  always_comb begin
    rdata_merge = rdata_q;
    rdata_merge[{beat_q, 3'b000} +: 8] = mem_rdata;
  end

  // Port outputs are derived from the state so they read 0 outside ACCESS.
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_req && cap_wr_q;
  assign mem_addr  = mem_req ? beat_addr : '0;
  assign mem_wdata = mem_we ? cap_wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
  // Stall must be visible in the capture cycle so upstream holds the next one.
  assign stall_out = (state_q == S_ACCESS) ||
                     (state_q == S_IDLE && in_valid && in_access);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    rdata_d      = rdata_q;
    cap_wb_d     = cap_wb_q;
    cap_res_d    = cap_res_q;
    cap_dest_d   = cap_dest_q;
    cap_stride_d = cap_stride_q;
    cap_wdata_d  = cap_wdata_q;
    cap_wr_d     = cap_wr_q;
    cap_vec_d    = cap_vec_q;
    cap_byte_d   = cap_byte_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_access) begin
            cap_wb_d     = wb_in;
            cap_res_d    = res_alu_in;
            cap_dest_d   = dest_in;
            cap_stride_d = r1_in[7:0];
            cap_wdata_d  = r2_in;
            cap_wr_d     = in_wr;
            cap_vec_d    = mem_in[MEM_VEC];
            cap_byte_d   = mem_in[MEM_BYTE];
            beat_d       = '0;
            rdata_d      = '0;
            state_d      = S_ACCESS;
          end else begin
            // No-op or illegal read+write: forward the bundle directly.
            out_d       = '{wb: wb_in, res_alu: res_alu_in, rdata: 32'h0, dest: dest_in};
            out_valid_d = 1'b1;
            err_d       = in_rd && in_wr;
            state_d     = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          if (!cap_wr_q) begin
            rdata_d = rdata_merge;
          end
          if (beat_q == last_beat) begin
            out_d       = '{wb: cap_wb_q, res_alu: cap_res_q,
                            rdata: cap_wr_q ? 32'h0 : rdata_merge, dest: cap_dest_q};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      rdata_q      <= '0;
      cap_wb_q     <= '0;
      cap_res_q    <= '0;
      cap_dest_q   <= '0;
      cap_stride_q <= '0;
      cap_wdata_q  <= '0;
      cap_wr_q     <= 1'b0;
      cap_vec_q    <= 1'b0;
      cap_byte_q   <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      rdata_q      <= rdata_d;
      cap_wb_q     <= cap_wb_d;
      cap_res_q    <= cap_res_d;
      cap_dest_q   <= cap_dest_d;
      cap_stride_q <= cap_stride_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_wr_q     <= cap_wr_d;
      cap_vec_q    <= cap_vec_d;
      cap_byte_q   <= cap_byte_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  assign wb_out      = out_q.wb;
  assign res_alu_out = out_q.res_alu;
  assign rdata_out   = out_q.rdata;
  assign dest_out    = out_q.dest;
  assign out_valid   = out_valid_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench: hand-written vector table, randomized operations
// checked against a behavioural model, and reset / stray-ack sequences.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int ADDR_W = 16;
  localparam int LOG_W  = 1 + ADDR_W + 8;

  typedef struct {
    logic [4:0]  mem_in;
    logic [1:0]  wb;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] res;
    logic [3:0]  dest;
    int          delay;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } op_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        mem_in;
  logic [1:0]        wb_in;
  logic [31:0]       r1_in, r2_in, res_alu_in;
  logic [3:0]        dest_in;
  logic              in_valid;
  logic              stall_out, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [1:0]        wb_out;
  logic [31:0]       res_alu_out, rdata_out;
  logic [3:0]        dest_out;
  logic              out_valid, err_out;

  // Memory responder state and scoreboard.
  logic [7:0]       mem [0:65535];
  logic [LOG_W-1:0] beat_log [$];
  logic [LOG_W-1:0] exp_q [$];
  int               ack_delay;
  bit               spurious_ack;
  int               wait_cnt;
  int               stable_err;
  logic [LOG_W-1:0] held_beat;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.ADDR_W(ADDR_W), .BEATS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_in      (mem_in),
    .wb_in       (wb_in),
    .r1_in       (r1_in),
    .r2_in       (r2_in),
    .res_alu_in  (res_alu_in),
    .dest_in     (dest_in),
    .in_valid    (in_valid),
    .stall_out   (stall_out),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_out      (wb_out),
    .res_alu_out (res_alu_out),
    .rdata_out   (rdata_out),
    .dest_out    (dest_out),
    .out_valid   (out_valid),
    .err_out     (err_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  // Drives ack/rdata on the falling edge so the DUT samples them on the next
  // rising edge; each beat is acked after ack_delay idle request cycles.
  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00; wait_cnt = 0; stable_err = 0;
    held_beat = '0;
    forever begin
      @(negedge clk);
      if (spurious_ack) begin
        mem_ack = 1'b1; mem_rdata = 8'hEE; wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt == 0) held_beat = {mem_we, mem_addr, mem_wdata};
        else if (held_beat !== {mem_we, mem_addr, mem_wdata}) stable_err++;
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            beat_log.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem[mem_addr];
            beat_log.push_back({1'b0, mem_addr, mem[mem_addr]});
          end
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0; wait_cnt = 0;
      end
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int n_beats(op_t op);
    if (op.mem_in[0] == op.mem_in[1]) return 0;
    return (op.mem_in[2] || !op.mem_in[3]) ? 4 : 1;
  endfunction

  function automatic logic [15:0] beat_addr(op_t op, int i);
    int step;
    step = op.mem_in[2] ? int'(op.r1[7:0]) : 1;
    return 16'((int'(op.res[15:0]) + i * step) % 65536);
  endfunction

  function automatic op_t fill_exp(op_t op);
    op_t o = op;
    int  nb = n_beats(op);
    o.err   = op.mem_in[0] & op.mem_in[1];
    o.lat   = (nb == 0) ? 1 : nb * (op.delay + 1) + 1;
    o.rdata = 32'h0;
    if (op.mem_in[0] && !op.mem_in[1])
      for (int i = 0; i < nb; i++)
        o.rdata = o.rdata | (32'(mem[beat_addr(op, i)]) << (8 * i));
    return o;
  endfunction

  function automatic op_t mk(logic [4:0] m, logic [1:0] wb, logic [31:0] r1,
                             logic [31:0] r2, logic [31:0] res, logic [3:0] dest,
                             int delay, int lat, logic [31:0] rdata, logic err);
    op_t o;
    o.mem_in = m; o.wb = wb; o.r1 = r1; o.r2 = r2; o.res = res; o.dest = dest;
    o.delay = delay; o.lat = lat; o.rdata = rdata; o.err = err;
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input op_t op);
    int  nb, lat;
    bit  seen, stall_ok, is_acc;
    logic [15:0] a;
    nb = n_beats(op);
    is_acc = (nb != 0);
    exp_q.delete();
    for (int i = 0; i < nb; i++) begin
      a = beat_addr(op, i);
      if (op.mem_in[1]) exp_q.push_back({1'b1, a, op.r2[8*i +: 8]});
      else              exp_q.push_back({1'b0, a, mem[a]});
    end
    beat_log.delete();
    stable_err = 0;
    ack_delay  = op.delay;

    @(negedge clk);
    mem_in = op.mem_in; wb_in = op.wb; r1_in = op.r1; r2_in = op.r2;
    res_alu_in = op.res; dest_in = op.dest; in_valid = 1'b1;
    #1 chk("stall_capture", stall_out, is_acc);
    @(posedge clk);
    #1 in_valid = 1'b0;

    lat = 0; seen = 0; stall_ok = 1;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
      else if (stall_out !== is_acc) stall_ok = 0;
    end
    chk("out_valid_seen", seen, 1'b1);
    if (seen) begin
      chk("latency", lat, op.lat);
      chk("fields", {wb_out, res_alu_out, dest_out}, {op.wb, op.res, op.dest});
      chk("rdata", rdata_out, op.rdata);
      chk("err", err_out, op.err);
      chk("stall_at_valid", stall_out, 1'b0);
    end
    chk("stall_hold", stall_ok, 1'b1);
    @(negedge clk);
    chk("strobe_end", {out_valid, err_out, mem_req}, 3'b000);
    chk("held", {wb_out, res_alu_out, rdata_out, dest_out},
        {op.wb, op.res, op.rdata, op.dest});
    chk("beat_count", beat_log.size(), exp_q.size());
    while (exp_q.size() > 0 && beat_log.size() > 0)
      chk("beat", beat_log.pop_front(), exp_q.pop_front());
    chk("req_stable", stable_err, 0);
  endtask

  // ---------------- stimulus ----------------
  op_t tbl [10];
  op_t rop;
  bit  quiet_ok;
  int  guard;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mem_in = '0; wb_in = '0; r1_in = '0;
    r2_in = '0; res_alu_in = '0; dest_in = '0; ack_delay = 0; spurious_ack = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFF0] = 8'h11; mem[16'h0000] = 8'h22;
    mem[16'h0010] = 8'h33; mem[16'h0020] = 8'h44;
    mem[16'h0042] = 8'h9C;
    mem[16'h0400] = 8'h01; mem[16'h0402] = 8'h02;
    mem[16'h0404] = 8'h03; mem[16'h0406] = 8'h04;

    tbl[0] = mk(5'b00000, 2'b11, 32'h0,  32'h0,        32'h1234, 4'd5, 0, 1, 32'h0,        1'b0);
    tbl[1] = mk(5'b00010, 2'b01, 32'h0,  32'hA1B2C3D4, 32'h0100, 4'd2, 0, 5, 32'h0,        1'b0);
    tbl[2] = mk(5'b00001, 2'b10, 32'h0,  32'h0,        32'h0100, 4'd3, 0, 5, 32'hA1B2C3D4, 1'b0);
    tbl[3] = mk(5'b00101, 2'b01, 32'h10, 32'h0,        32'hFFF0, 4'd7, 0, 5, 32'h44332211, 1'b0);
    tbl[4] = mk(5'b01001, 2'b10, 32'h0,  32'h0,        32'h0042, 4'd4, 3, 5, 32'h0000009C, 1'b0);
    tbl[5] = mk(5'b00011, 2'b01, 32'h0,  32'h0,        32'hBEEF, 4'd9, 0, 1, 32'h0,        1'b1);
    tbl[6] = mk(5'b00110, 2'b11, 32'h0,  32'h55667788, 32'h0300, 4'd1, 0, 5, 32'h0,        1'b0);
    tbl[7] = mk(5'b01101, 2'b01, 32'h2,  32'h0,        32'h0400, 4'd6, 1, 9, 32'h04030201, 1'b0);
    tbl[8] = mk(5'b01010, 2'b00, 32'h0,  32'h000000AB, 32'h0500, 4'd8, 0, 2, 32'h0,        1'b0);
    tbl[9] = mk(5'b01001, 2'b11, 32'h0,  32'h0,        32'h0300, 4'd0, 0, 2, 32'h00000055, 1'b0);

    repeat (3) @(negedge clk);
    #1 chk("reset_outputs",
           {stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_out, res_alu_out,
            rdata_out, dest_out, out_valid, err_out}, '0);
    @(negedge clk) rst_n = 1'b1;

    for (int t = 0; t < 10; t++) run_op(tbl[t]);

    for (int t = 0; t < 40; t++) begin
      rop.mem_in = 5'($urandom);
      rop.wb     = 2'($urandom);
      rop.r1     = $urandom;
      rop.r2     = $urandom;
      rop.res    = $urandom;
      rop.dest   = 4'($urandom);
      rop.delay  = $urandom_range(0, 2);
      rop = fill_exp(rop);
      run_op(rop);
    end

    // Reset in the middle of a vector store, with stray acks around it.
    beat_log.delete();
    ack_delay = 1;
    @(negedge clk);
    mem_in = 5'b00110; wb_in = 2'b10; r1_in = 32'h4; r2_in = 32'h0BADF00D;
    res_alu_in = 32'h0600; dest_in = 4'd11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    while (beat_log.size() < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("two_beats_before_reset", beat_log.size(), 2);
    @(negedge clk);
    rst_n = 1'b0; spurious_ack = 1;
    #1 chk("reset_mid_access",
           {stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_out, res_alu_out,
            rdata_out, dest_out, out_valid, err_out}, '0);
    @(negedge clk) rst_n = 1'b1;
    quiet_ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || mem_req || stall_out || err_out) quiet_ok = 0;
    end
    spurious_ack = 0;
    chk("no_valid_after_reset", quiet_ok, 1'b1);
    chk("no_beats_after_reset", beat_log.size(), 2);
    run_op(mk(5'b00000, 2'b01, 32'h0, 32'h0, 32'h00C0FFEE, 4'd12, 0, 1, 32'h0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
